// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns byte/half/word load and store requests into
// word-wide memory cycles. Sub-word stores use read-modify-write, and the
// unit rejects misaligned, out-of-range and reserved-size requests without
// touching memory. A saturating counter tallies the error responses.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; memory write-protected
// READ  | mem_addr driven, mem_rdata captured (load or RMW fetch)
// WRITE | mem_we high, mem_mode low, full/merged word on mem_wdata
// RESP  | response held until rsp_ready
module dmem_access_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic        mem_mode,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [7:0]  mem_addr_q;
  logic        mem_we_q;
  logic        mem_mode_q;
  logic [31:0] mem_wdata_q;
  logic [7:0]  err_count_q;

  logic        acc_err;

  // Picks the addressed lane out of a memory word and extends it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replaces only the addressed lane of the fetched word with store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] off, input logic [1:0] size);
    logic [31:0] r;
    r = w;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Request legality, evaluated on the live request inputs at acceptance.
  always_comb begin
    acc_err = (req_size == SZ_RSVD)
            | ((req_size == SZ_HALF) & req_addr[0])
            | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
            | ({24'd0, req_addr} >= 32'(MEM_BYTES));
  end

  // Sequencer with all outputs registered; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= 1'b1;
      mem_wdata_q <= 32'd0;
      err_count_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q       <= req_addr[1:0];
            size_q      <= req_size;
            signed_q    <= req_signed;
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            mem_addr_q  <= {req_addr[7:2], 2'b00};
            req_ready_q <= 1'b0;
            if (acc_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state_q     <= WRITE;
              mem_we_q    <= 1'b1;
              mem_mode_q  <= 1'b0;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            state_q     <= WRITE;
            mem_we_q    <= 1'b1;
            mem_mode_q  <= 1'b0;
            mem_wdata_q <= merge(mem_rdata, wdata_q, off_q, size_q);
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= extract(mem_rdata, off_q, size_q, signed_q);
          end
        end
        WRITE: begin
          state_q     <= RESP;
          mem_we_q    <= 1'b0;
          mem_mode_q  <= 1'b1;
          mem_wdata_q <= 32'd0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            req_ready_q <= 1'b1;
            if (rsp_err_q && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_mode_q  <= 1'b1;
          mem_wdata_q <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_mode  = mem_mode_q;
  assign mem_wdata = mem_wdata_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural word memory and a
// queue of expected responses.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic        mem_mode;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  dmem_access_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_count(err_count)
  );

  logic [31:0] mem [0:63];
  int wr_cnt = 0;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) if (mem_we && !mem_mode) mem[mem_addr[7:2]] <= mem_wdata;
  always @(posedge clk) if (mem_we) wr_cnt <= wr_cnt + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [7:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int hold, input logic early);
    exp_t e;
    int n;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata; rsp_ready = early;
    e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = 8'hFF; req_size = 2'b11;
    req_wdata = 32'hDEADBEEF;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    if (!rsp_valid) begin
      void'(sb.pop_front());
      rsp_ready = 1'b0;
      return;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, sb[0].rdata);
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    e = sb.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_no_dup"}, 32'(rsp_valid), 32'd0);
  endtask

  int wr0;
  int n;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[1] = 32'd3;
    mem[2] = 32'd1;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_mode", 32'(mem_mode), 32'd1);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    access("ld_w4", 1'b0, 8'd4, 2'b10, 1'b0, 32'd0, 32'h00000003, 1'b0, 2, 0, 1'b0);
    access("st_b9", 1'b1, 8'd9, 2'b00, 1'b0, 32'h000000AB, 32'd0, 1'b0, 3, 0, 1'b0);
    check("mem8_after_sb", mem[2], 32'h0000AB01);
    access("ld_b9_s", 1'b0, 8'd9, 2'b00, 1'b1, 32'd0, 32'hFFFFFFAB, 1'b0, 2, 0, 1'b0);
    access("ld_b9_u", 1'b0, 8'd9, 2'b00, 1'b0, 32'd0, 32'h000000AB, 1'b0, 2, 0, 1'b0);
    access("st_h10", 1'b1, 8'd10, 2'b01, 1'b0, 32'h1234BEEF, 32'd0, 1'b0, 3, 0, 1'b0);
    check("mem8_after_sh", mem[2], 32'hBEEFAB01);
    access("ld_h10_u", 1'b0, 8'd10, 2'b01, 1'b0, 32'd0, 32'h0000BEEF, 1'b0, 2, 0, 1'b0);
    access("ld_h10_s", 1'b0, 8'd10, 2'b01, 1'b1, 32'd0, 32'hFFFFBEEF, 1'b0, 2, 0, 1'b0);
    access("st_w12", 1'b1, 8'd12, 2'b10, 1'b0, 32'h12345678, 32'd0, 1'b0, 2, 0, 1'b0);
    check("mem12_after_sw", mem[3], 32'h12345678);
    access("ld_b15_early", 1'b0, 8'd15, 2'b00, 1'b0, 32'd0, 32'h00000012, 1'b0, 2, 0, 1'b1);
    access("ld_h12_s", 1'b0, 8'd12, 2'b01, 1'b1, 32'd0, 32'h00005678, 1'b0, 2, 0, 1'b0);
    access("ld_b8_s", 1'b0, 8'd8, 2'b00, 1'b1, 32'd0, 32'h00000001, 1'b0, 2, 0, 1'b0);
    access("ld_w8_hold", 1'b0, 8'd8, 2'b10, 1'b0, 32'd0, 32'hBEEFAB01, 1'b0, 2, 5, 1'b0);
    access("ld_b63", 1'b0, 8'd63, 2'b00, 1'b0, 32'd0, 32'h00000000, 1'b0, 2, 0, 1'b0);

    wr0 = wr_cnt;
    access("err_w2", 1'b0, 8'd2, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0);
    access("err_h5", 1'b1, 8'd5, 2'b01, 1'b0, 32'h0000FFFF, 32'd0, 1'b1, 1, 0, 1'b0);
    access("err_sz3", 1'b0, 8'd0, 2'b11, 1'b0, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0);
    check("err_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("err_count_3", 32'(err_count), 32'd3);
    access("err_w64", 1'b0, 8'd64, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1, 0, 1'b1);
    access("err_sw64", 1'b1, 8'd64, 2'b10, 1'b0, 32'hCAFEF00D, 32'd0, 1'b1, 1, 0, 1'b0);
    check("oor_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("err_count_5", 32'(err_count), 32'd5);
    for (int i = 0; i < 256; i++)
      access("err_sat", 1'b0, 8'd64, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 1, 0, 1'b1);
    check("err_count_sat", 32'(err_count), 32'd255);

    // Reset while the merged word of a sub-word store is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd13; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = 32'h00000055;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rstw_mem_we", 32'(mem_we), 32'd1);
    check("rstw_mem_mode", 32'(mem_mode), 32'd0);
    check("rstw_mem_wdata", mem_wdata, 32'h12345578);
    check("rstw_mem_addr", 32'(mem_addr), 32'd12);
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rstw_we_off", 32'(mem_we), 32'd0);
    check("rstw_mode_on", 32'(mem_mode), 32'd1);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstw_no_we", 32'(mem_we), 32'd0);
    end

    access("ld_w4_post", 1'b0, 8'd4, 2'b10, 1'b0, 32'd0, 32'h00000003, 1'b0, 2, 0, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
